// File: rtl/cc_muxx_pkg.sv
// ============================================================================
// Module   : cc_muxx_pkg
// Brief    : Shared mode constants and output-stage state type for cc_muxx_rr_reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cc_muxx_pkg;

  localparam logic MODE_FIXED       = 1'b0;
  localparam logic MODE_ROUND_ROBIN = 1'b1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

`default_nettype wire

// File: rtl/cc_rr_arbiter.sv
// ============================================================================
// Module   : cc_rr_arbiter
// Brief    : Combinational rotate-priority search; first requester after i_ptr wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_rr_arbiter #(
  parameter int NUM_CHANNELS = 8,
  parameter int IDX_W        = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] i_req,
  input  logic [IDX_W-1:0]        i_ptr,
  output logic                    o_grant_valid,
  output logic [IDX_W-1:0]        o_grant_idx
);

  // i_ptr < NUM_CHANNELS and off <= NUM_CHANNELS, so one subtraction wraps.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NUM_CHANNELS) s = s - NUM_CHANNELS;
    return IDX_W'(s);
  endfunction

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    for (int off = NUM_CHANNELS; off >= 1; off--) begin
      if (i_req[wrap_idx(i_ptr, off)]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = wrap_idx(i_ptr, off);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cc_muxx_rr_reg.sv
// ============================================================================
// Module   : cc_muxx_rr_reg
// Brief    : NUM_CHANNELS-input registered mux, FIXED or ROUND_ROBIN, valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_muxx_rr_reg
  import cc_muxx_pkg::*;
#(
  parameter int DATAWIDTH_BUS           = 8,
  parameter int NUM_CHANNELS            = 8,
  parameter int DATAWIDTH_MUX_SELECTION = 3
) (
  input  logic                                  CC_MUXX_CLOCK_50,
  input  logic                                  CC_MUXX_RESET_InLow,
  input  logic                                  CC_MUXX_mode_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]    CC_MUXX_selection_InBUS,
  input  logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0] CC_MUXX_data_InBUS,
  input  logic [NUM_CHANNELS-1:0]               CC_MUXX_valid_InBUS,
  output logic [NUM_CHANNELS-1:0]               CC_MUXX_ready_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]              CC_MUXX_data_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]    CC_MUXX_channel_OutBUS,
  output logic                                  CC_MUXX_valid_Out,
  input  logic                                  CC_MUXX_ready_In
);

  localparam int SEL_W = DATAWIDTH_MUX_SELECTION;

  out_state_t                  r_state;
  logic [SEL_W-1:0]            r_ptr;
  logic [DATAWIDTH_BUS-1:0]    r_data;
  logic [SEL_W-1:0]            r_chan;

  logic                        w_load_en;
  logic [(2**SEL_W)-1:0]       w_valid_ext;
  logic                        w_fix_valid;
  logic                        w_rr_valid;
  logic [SEL_W-1:0]            w_rr_idx;
  logic                        w_grant_valid;
  logic [SEL_W-1:0]            w_grant_idx;
  logic [DATAWIDTH_BUS-1:0]    w_data_sel;

  // Zero-padded valid vector: an out-of-range selection reads 0, never X.
  always_comb begin
    w_valid_ext                   = '0;
    w_valid_ext[NUM_CHANNELS-1:0] = CC_MUXX_valid_InBUS;
  end

  assign w_fix_valid = w_valid_ext[CC_MUXX_selection_InBUS];

  cc_rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .IDX_W        (SEL_W)
  ) u_arb (
    .i_req         (CC_MUXX_valid_InBUS),
    .i_ptr         (r_ptr),
    .o_grant_valid (w_rr_valid),
    .o_grant_idx   (w_rr_idx)
  );

  assign w_grant_valid = (CC_MUXX_mode_In == MODE_ROUND_ROBIN) ? w_rr_valid : w_fix_valid;
  assign w_grant_idx   = (CC_MUXX_mode_In == MODE_ROUND_ROBIN) ? w_rr_idx   : CC_MUXX_selection_InBUS;
  assign w_load_en     = (r_state == ST_EMPTY) || CC_MUXX_ready_In;

  always_comb begin
    w_data_sel = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (w_grant_idx == SEL_W'(k)) w_data_sel = CC_MUXX_data_InBUS[k*DATAWIDTH_BUS +: DATAWIDTH_BUS];
    end
  end

  // Accept is forced low while reset is asserted, independent of the state register.
  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ready
    assign CC_MUXX_ready_OutBUS[k] = CC_MUXX_RESET_InLow && w_load_en && w_grant_valid &&
                                     (w_grant_idx == SEL_W'(k));
  end

  always_ff @(posedge CC_MUXX_CLOCK_50 or negedge CC_MUXX_RESET_InLow) begin
    if (!CC_MUXX_RESET_InLow) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= SEL_W'(NUM_CHANNELS - 1);
    end else if (w_load_en) begin
      if (w_grant_valid) begin
        r_state <= ST_FULL;
        r_data  <= w_data_sel;
        r_chan  <= w_grant_idx;
        if (CC_MUXX_mode_In == MODE_ROUND_ROBIN) r_ptr <= w_grant_idx;
      end else begin
        r_state <= ST_EMPTY;
      end
    end
  end

  assign CC_MUXX_data_OutBUS    = r_data;
  assign CC_MUXX_channel_OutBUS = r_chan;
  assign CC_MUXX_valid_Out      = (r_state == ST_FULL);

endmodule

`default_nettype wire

// File: tb/tb_cc_muxx_rr_reg.sv
// ============================================================================
// Module   : tb_cc_muxx_rr_reg
// Brief    : Directed-vector bench for cc_muxx_rr_reg (8-channel and 6-channel builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cc_muxx_rr_reg;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        mode8, ready8;
  logic [2:0]  sel8;
  logic [63:0] data8;
  logic [7:0]  valid8, rdy8;
  logic [7:0]  dout8;
  logic [2:0]  ch8;
  logic        vout8;

  logic        mode6, ready6;
  logic [2:0]  sel6;
  logic [47:0] data6;
  logic [5:0]  valid6, rdy6;
  logic [7:0]  dout6;
  logic [2:0]  ch6;
  logic        vout6;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cc_muxx_rr_reg #(.DATAWIDTH_BUS(8), .NUM_CHANNELS(8), .DATAWIDTH_MUX_SELECTION(3)) dut8 (
    .CC_MUXX_CLOCK_50        (clk),
    .CC_MUXX_RESET_InLow     (rst_n),
    .CC_MUXX_mode_In         (mode8),
    .CC_MUXX_selection_InBUS (sel8),
    .CC_MUXX_data_InBUS      (data8),
    .CC_MUXX_valid_InBUS     (valid8),
    .CC_MUXX_ready_OutBUS    (rdy8),
    .CC_MUXX_data_OutBUS     (dout8),
    .CC_MUXX_channel_OutBUS  (ch8),
    .CC_MUXX_valid_Out       (vout8),
    .CC_MUXX_ready_In        (ready8)
  );

  cc_muxx_rr_reg #(.DATAWIDTH_BUS(8), .NUM_CHANNELS(6), .DATAWIDTH_MUX_SELECTION(3)) dut6 (
    .CC_MUXX_CLOCK_50        (clk),
    .CC_MUXX_RESET_InLow     (rst_n),
    .CC_MUXX_mode_In         (mode6),
    .CC_MUXX_selection_InBUS (sel6),
    .CC_MUXX_data_InBUS      (data6),
    .CC_MUXX_valid_InBUS     (valid6),
    .CC_MUXX_ready_OutBUS    (rdy6),
    .CC_MUXX_data_OutBUS     (dout6),
    .CC_MUXX_channel_OutBUS  (ch6),
    .CC_MUXX_valid_Out       (vout6),
    .CC_MUXX_ready_In        (ready6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input int ch, input logic v);
    chk({tag, "_valid"}, 32'(vout8), 32'(v));
    chk({tag, "_chan"},  32'(ch8),   32'(ch));
    chk({tag, "_data"},  32'(dout8), 32'h0A0 + 32'(ch));
  endtask

  int fair_seq [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
  int skip_seq [4]  = '{1, 7, 1, 7};

  initial begin
    for (int k = 0; k < 8; k++) data8[k*8 +: 8] = 8'hA0 + 8'(k);
    for (int k = 0; k < 6; k++) data6[k*8 +: 8] = 8'hB0 + 8'(k);
    rst_n  = 1'b0;
    mode8  = 1'b0; sel8 = 3'd5; valid8 = 8'hFF; ready8 = 1'b1;
    mode6  = 1'b0; sel6 = 3'd7; valid6 = 6'h3F; ready6 = 1'b1;

    // Reset held with live requests.
    repeat (3) step();
    chk("rst_valid", 32'(vout8), 32'd0);
    chk("rst_data",  32'(dout8), 32'd0);
    chk("rst_chan",  32'(ch8),   32'd0);
    chk("rst_ready", 32'(rdy8),  32'd0);
    chk("rst_ready6", 32'(rdy6), 32'd0);
    rst_n  = 1'b1;
    valid8 = 8'h00;

    // Six-channel build: out-of-range selection never grants.
    #1;
    chk("oor_ready", 32'(rdy6), 32'd0);
    step();
    chk("oor_valid", 32'(vout6), 32'd0);
    chk("oor_data",  32'(dout6), 32'd0);
    chk("oor_chan",  32'(ch6),   32'd0);
    sel6 = 3'd5;
    #1;
    chk("fix6_ready", 32'(rdy6), 32'h20);
    step();
    chk("fix6_data", 32'(dout6), 32'hB5);
    chk("fix6_chan", 32'(ch6),   32'd5);
    mode6 = 1'b1;
    #1;
    chk("rr6_ready", 32'(rdy6), 32'h01);
    step();
    chk("rr6_chan", 32'(ch6), 32'd0);

    // FIXED selection of channel 5.
    mode8 = 1'b0; sel8 = 3'd5; valid8 = 8'b0010_0000; ready8 = 1'b1;
    #1;
    chk("fix_ready", 32'(rdy8), 32'h20);
    step();
    chk8("fix", 5, 1'b1);

    // Round-robin fairness from the reset pointer (7).
    mode8 = 1'b1; valid8 = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      chk8($sformatf("fair%0d", i), fair_seq[i], 1'b1);
    end

    // Park pointer on 7, then skip/wrap between channels 1 and 7.
    valid8 = 8'h80;
    step();
    chk8("park", 7, 1'b1);
    valid8 = 8'b1000_0010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk8($sformatf("skip%0d", i), skip_seq[i], 1'b1);
    end

    // Backpressure: hold the channel-7 word for 4 cycles.
    valid8 = 8'hFF; ready8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp%0d_ready", i), 32'(rdy8), 32'd0);
      step();
      chk8($sformatf("bp%0d", i), 7, 1'b1);
    end
    ready8 = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(rdy8), 32'h01);
    step();
    chk8("bp_rel", 0, 1'b1);

    // Mode switch: FIXED load must not move the round-robin pointer.
    mode8 = 1'b0; sel8 = 3'd3;
    #1;
    chk("sw_fix_ready", 32'(rdy8), 32'h08);
    step();
    chk8("sw_fix", 3, 1'b1);
    mode8 = 1'b1;
    #1;
    chk("sw_rr_ready", 32'(rdy8), 32'h02);
    step();
    chk8("sw_rr", 1, 1'b1);

    // Drain to EMPTY; word and channel hold.
    valid8 = 8'h00;
    #1;
    chk("drain_ready", 32'(rdy8), 32'd0);
    step();
    chk8("drain", 1, 1'b0);

    // EMPTY stage loads regardless of consumer ready.
    valid8 = 8'h04; ready8 = 1'b0;
    #1;
    chk("empty_ready", 32'(rdy8), 32'h04);
    step();
    chk8("empty_load", 2, 1'b1);

    // Asynchronous reset between clock edges.
    valid8 = 8'hFF; ready8 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(vout8), 32'd0);
    chk("arst_data",  32'(dout8), 32'd0);
    chk("arst_chan",  32'(ch8),   32'd0);
    chk("arst_ready", 32'(rdy8),  32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("arst_rel_ready", 32'(rdy8), 32'h01);
    step();
    chk8("arst_rel", 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
